// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing the async FIFO write port, throttled by full_i
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 16
) (
    input  logic                      clk_write_i,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ack_o,
    output logic [NUM_REQ-1:0]        grant_o,
    input  logic                      full_i,
    output logic                      wr_req_o,
    output logic [DATA_W-1:0]         wr_data_o,
    output logic                      busy_o,
    output logic [31:0]               words_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, BURST} state_t;
    state_t        state;
    logic [PW-1:0] ptr, win, idx;
    logic [BW-1:0] burst_cnt;
    logic          own_valid, ack, last;
    // Scan from farthest to nearest so the requester right after ptr wins; ptr itself is checked last
    always_comb begin
        win = ptr;
        idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (req_valid_i[idx]) win = idx;
        end
    end
    assign busy_o    = state == BURST;
    assign own_valid = req_valid_i[ptr];
    assign ack       = busy_o & own_valid & ~full_i;
    assign last      = (ack && burst_cnt == BW'(MAX_BURST - 1)) || !own_valid;
    assign req_ack_o = NUM_REQ'(ack) << ptr;
    assign wr_req_o  = ack;
    assign wr_data_o = ack ? req_data_i[ptr*DATA_W +: DATA_W] : '0;
    always_ff @(posedge clk_write_i or negedge reset_i) begin
        if (!reset_i) begin
            state       <= IDLE;
            ptr         <= PW'(NUM_REQ - 1);
            grant_o     <= '0;
            burst_cnt   <= '0;
            words_o     <= '0;
            stall_cnt_o <= '0;
        end else if (state == IDLE) begin
            if (|req_valid_i) begin
                state     <= BURST;
                ptr       <= win;
                grant_o   <= NUM_REQ'(1) << win;
                burst_cnt <= '0;
            end
        end else begin
            if (ack) words_o <= words_o + 32'd1;
            if (full_i && own_valid && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
            if (last) begin
                burst_cnt <= '0;
                if (|req_valid_i) begin
                    ptr     <= win;
                    grant_o <= NUM_REQ'(1) << win;
                end else begin
                    state   <= IDLE;
                    grant_o <= '0;
                end
            end else if (ack) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed checks of grant order, burst limit, backpressure and async reset
module tb_fifo_write_arbiter;
    logic        clk = 0, rst_n = 0, full = 0;
    logic [3:0]  valid = 0;
    logic [31:0] d [4];
    logic [127:0] req_data;
    logic [3:0]  ack, grant;
    logic        wr_req, busy;
    logic [31:0] wr_data, words;
    logic [15:0] stall;
    int n_pass = 0, n_total = 0;

    assign req_data = {d[3], d[2], d[1], d[0]};
    always #5 clk = ~clk;

    fifo_write_arbiter dut (
        .clk_write_i(clk), .reset_i(rst_n), .req_valid_i(valid), .req_data_i(req_data),
        .req_ack_o(ack), .grant_o(grant), .full_i(full), .wr_req_o(wr_req),
        .wr_data_o(wr_data), .busy_o(busy), .words_o(words), .stall_cnt_o(stall)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 0;
        valid = 0;
        full  = 0;
        tick;
        tick;
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        foreach (d[i]) d[i] = 0;
        // Reset held with every requester valid
        valid = 4'hF;
        tick;
        tick;
        chk("rst_grant", grant, 0);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_ack", ack, 0);
        chk("rst_words", words, 0);
        chk("rst_stall", stall, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1;
        #1;
        chk("rel_grant_latency", grant, 0);
        tick;
        chk("rel_first_grant", grant, 4'b0001);
        chk("rel_busy", busy, 1);

        // Single streamer: 20 words, bursts chain with no gap
        do_reset;
        valid = 4'b0001;
        tick;
        chk("ss_grant", grant, 4'b0001);
        for (int i = 0; i < 20; i++) begin
            d[0] = 32'h100 + i;
            #1;
            chk("ss_wr_req", wr_req, 1);
            chk("ss_data", wr_data, 32'h100 + i);
            chk("ss_ack", ack, 4'b0001);
            chk("ss_grant_hold", grant, 4'b0001);
            chk("ss_words_run", words, i);
            tick;
        end
        chk("ss_words", words, 20);
        valid = 0;
        #1;
        chk("ss_drop_wr_req", wr_req, 0);
        tick;
        chk("ss_idle_grant", grant, 0);
        chk("ss_idle_busy", busy, 0);

        // Fairness: all valid, 8-word bursts in rotation
        do_reset;
        foreach (d[i]) d[i] = 32'hD0 + i;
        valid = 4'hF;
        tick;
        for (int g = 0; g < 5; g++)
            for (int w = 0; w < 8; w++) begin
                #1;
                chk("fair_grant", grant, 64'(1) << (g % 4));
                chk("fair_ack", ack, 64'(1) << (g % 4));
                chk("fair_data", wr_data, 32'hD0 + (g % 4));
                tick;
            end
        chk("fair_words", words, 40);
        chk("fair_next_grant", grant, 4'b0010);
        valid = 0;
        tick;

        // Backpressure: full for 5 cycles after 3 words of req1
        do_reset;
        valid = 4'b0010;
        tick;
        chk("bp_grant", grant, 4'b0010);
        for (int w = 0; w < 3; w++) begin
            d[1] = 32'h200 + w;
            #1;
            chk("bp_wr_req", wr_req, 1);
            chk("bp_data", wr_data, 32'h200 + w);
            tick;
        end
        full = 1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_full_wr_req", wr_req, 0);
            chk("bp_full_ack", ack, 0);
            chk("bp_full_grant", grant, 4'b0010);
            tick;
            chk("bp_stall_run", stall, c + 1);
        end
        chk("bp_words_stalled", words, 3);
        full = 0;
        for (int w = 3; w < 8; w++) begin
            d[1] = 32'h200 + w;
            #1;
            chk("bp_resume_wr_req", wr_req, 1);
            chk("bp_resume_data", wr_data, 32'h200 + w);
            tick;
        end
        chk("bp_words", words, 8);
        chk("bp_stall", stall, 5);
        chk("bp_regrant", grant, 4'b0010);
        valid = 0;
        tick;

        // Valid drop hands over to req2 with no idle cycle
        do_reset;
        d[0] = 32'hA0;
        d[2] = 32'hA2;
        valid = 4'b0101;
        tick;
        chk("vd_grant0", grant, 4'b0001);
        for (int w = 0; w < 3; w++) begin
            #1;
            chk("vd_ack0", ack, 4'b0001);
            tick;
        end
        valid = 4'b0100;
        #1;
        chk("vd_drop_wr_req", wr_req, 0);
        chk("vd_drop_ack", ack, 0);
        tick;
        chk("vd_grant2", grant, 4'b0100);
        chk("vd_words", words, 3);
        chk("vd_busy", busy, 1);
        #1;
        chk("vd_ack2", ack, 4'b0100);
        chk("vd_data2", wr_data, 32'hA2);
        valid = 0;
        tick;

        // Asynchronous reset in the middle of req3's burst
        do_reset;
        d[3] = 32'hB3;
        valid = 4'b1000;
        tick;
        chk("ar_grant3", grant, 4'b1000);
        tick;
        tick;
        chk("ar_words_pre", words, 2);
        #3;
        rst_n = 0;
        #1;
        chk("ar_grant", grant, 0);
        chk("ar_words", words, 0);
        chk("ar_stall", stall, 0);
        chk("ar_wr_req", wr_req, 0);
        chk("ar_ack", ack, 0);
        chk("ar_busy", busy, 0);
        valid = 4'hF;
        tick;
        chk("ar_hold_words", words, 0);
        chk("ar_hold_wr_req", wr_req, 0);
        rst_n = 1;
        tick;
        chk("ar_restart_grant", grant, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
